tkg_sync_arbiter: RTL and testbench
===================================

// Module: tkg_sync_arbiter
// PURPOSE
//  Clocked N-way arbiter sharing one four-phase resource port among N four-phase requesters.
//  It is the synchronous counterpart of the mutex element, used where a Teak four-phase
//  island meets a clocked shared resource, such as a memory or register-bank port.
//  It synchronises the async requests, picks one winner round-robin and sequences the
//  full four-phase cycle on the resource side. A watchdog flags a stuck resource handshake.
// PARAMETERS
//  N            4   number of requesters, 2..16
//  SYNC_STAGES  2   flop stages on every async input (rq, res_ak), 2..3
//  IDX_W        2   width of res_sel; must equal clog2(N)
//  TIMEOUT      0   cycles allowed in REQ/REL before err sets; 0 disables the watchdog
// PORTS
//  clk      in   1      clock, rising edge
//  reset_n  in   1      asynchronous, active-low reset
//  rq       in   N      per-requester four-phase request (async)
//  ak       out  N      per-requester four-phase acknowledge, registered, at most one bit high
//  res_rq   out  1      request to the shared resource, registered
//  res_sel  out  IDX_W  index of the current owner; stable whenever res_rq or any ak is high
//  res_ak   in   1      acknowledge from the shared resource (async)
//  busy     out  1      high in every state except IDLE
//  err      out  1      sticky watchdog flag
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE, ak=0, res_rq=0, res_sel=0, ptr=0, wdog=0, err=0, sync flops=0.
//  - All outputs come straight from flops, with no combinational path from inputs (glitch-free for async consumers).
//  - rq_s and res_ak_s are the SYNC_STAGES-delayed versions of rq and res_ak.
//    Every decision below uses only the synchronised versions.
//  - FSM, one transition per clk edge:
//    IDLE: if rq_s!=0, w = first set bit searching ptr, ptr+1, ... mod N.
//          Then res_sel<=w, res_rq<=1, ->REQ.
//    REQ:  if res_ak_s, ak[w]<=1, ->HOLD.
//    HOLD: if !rq_s[w], res_rq<=0, ->REL.
//    REL:  if !res_ak_s, ak[w]<=0, ptr<=(w+1) mod N, ->IDLE.
//  - Latency: rq rise to res_rq rise is SYNC_STAGES+1 cycles.
//    res_ak rise to ak rise is SYNC_STAGES+1 cycles.
//  - Four-phase order per requester: rq up, ak up, rq down, ak down.
//    The arbiter never lowers ak before it sees rq low.
//    The arbiter never raises res_rq again before res_ak_s is low.
//  - Mutual exclusion: the next winner is chosen only in IDLE, after the previous ak has fallen.
//  - Simultaneous requests: round-robin from ptr. The winner of one grant has the lowest priority in the next arbitration.
//  - Requests that drop before being granted (rq_s falls in IDLE) are ignored; this is a protocol violation upstream.
//    Requests of non-owners in REQ/HOLD/REL are held pending; they are not acknowledged.
//  - Watchdog: wdog counts cycles in REQ or REL and clears on every state change.
//    It saturates at TIMEOUT. When wdog==TIMEOUT and TIMEOUT!=0, err<=1 and stays 1 until reset.
//    The FSM keeps waiting; it never aborts a handshake.
//  - Reset mid-operation clears all outputs at once; the resource and requesters are reset by the same net.
//    After release, any rq still high is re-arbitrated from ptr=0.
//  - res_sel holds its last value in IDLE.
// TESTING
//  1. Single request: N=4, rq=0001, res_ak follows res_rq 2 cycles later.
//     -> res_rq rises 3 cycles after rq. ak[0] completes the four-phase cycle. ptr=1 at the end.
//  2. Simultaneous requests: rq=1111 held high, requesters drop rq 1 cycle after their ak.
//     -> grant order 0,1,2,3,0. ak is never more than one-hot. res_sel=0,1,2,3,0.
//  3. Fairness: rq[0] re-requests immediately after every grant, rq[2] is held high.
//     -> grants alternate 0,2,0,2. Neither requester waits longer than one other grant.
//  4. Stuck resource: TIMEOUT=8, res_ak tied 0, rq=0010.
//     -> err rises 9 cycles after entering REQ (wdog saturates at 8). busy=1. ak stays 0. State stays REQ.
//  5. Reset during HOLD: ak[1]=1, res_rq=1, then reset_n pulse of 1 cycle.
//     -> ak=0, res_rq=0, err=0 asynchronously. rq[1] still high is then granted again with ptr=0.
//  6. Input glitches: 1-cycle rq pulse shorter than a clk period is dropped before IDLE.
//     -> no res_rq. A random stall sweep on res_ak shows no exclusion or ordering violations (assertions).

Source files
------------

// File: rtl/tkg_sync_arbiter.sv
// Clocked N-way round-robin arbiter between four-phase requesters and one four-phase
// resource port, with input synchronisers and a sticky handshake watchdog.
module tkg_sync_arbiter #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     rq,
    output logic [N-1:0]     ak,
    output logic             res_rq,
    output logic [IDX_W-1:0] res_sel,
    input  logic             res_ak,
    output logic             busy,
    output logic             err
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0][N-1:0] rq_sync_r;
    logic [SYNC_STAGES-1:0]        ak_sync_r;
    logic [N-1:0]                  rq_s;
    logic                          res_ak_s;
    logic [IDX_W-1:0]              win_s;
    logic [IDX_W-1:0]              next_ptr_s;
    logic [WD_W-1:0]               wdog_inc_s;

    state_t           state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [WD_W-1:0]  wdog_r;
    logic [N-1:0]     ak_r;
    logic             res_rq_r;
    logic [IDX_W-1:0] sel_r;
    logic             busy_r;
    logic             err_r;

    // First set bit of req, searching upward from base and wrapping at N.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] req,
                                                 input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] res;
        logic             found;
        int               idx;
        res   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(base) + i) % N;
            if (!found && req[idx]) begin
                res   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] w);
        return IDX_W'((int'(w) + 1) % N);
    endfunction

    // Synchroniser chains for the asynchronous handshake inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rq_sync_r <= {(SYNC_STAGES*N){1'b0}};
            ak_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            rq_sync_r <= {rq_sync_r[SYNC_STAGES-2:0], rq};
            ak_sync_r <= {ak_sync_r[SYNC_STAGES-2:0], res_ak};
        end
    end

    // Arbitration choice, owner hand-off pointer and saturating watchdog step.
    always_comb begin
        rq_s       = rq_sync_r[SYNC_STAGES-1];
        res_ak_s   = ak_sync_r[SYNC_STAGES-1];
        win_s      = rr_pick(rq_s, ptr_r);
        next_ptr_s = rr_next(sel_r);
        if (wdog_r == WD_MAX) begin
            wdog_inc_s = wdog_r;
        end else begin
            wdog_inc_s = wdog_r + WD_W'(1);
        end
    end

    // Handshake sequencer: grant, resource request, owner release, resource release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {IDX_W{1'b0}};
            wdog_r   <= {WD_W{1'b0}};
            ak_r     <= {N{1'b0}};
            res_rq_r <= 1'b0;
            sel_r    <= {IDX_W{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|rq_s) begin
                        sel_r    <= win_s;
                        res_rq_r <= 1'b1;
                        busy_r   <= 1'b1;
                        wdog_r   <= {WD_W{1'b0}};
                        state_r  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (res_ak_s) begin
                        ak_r    <= ONE_N << sel_r;
                        wdog_r  <= {WD_W{1'b0}};
                        state_r <= ST_HOLD;
                    end else begin
                        wdog_r  <= wdog_inc_s;
                    end
                end
                ST_HOLD: begin
                    if (!rq_s[sel_r]) begin
                        res_rq_r <= 1'b0;
                        wdog_r   <= {WD_W{1'b0}};
                        state_r  <= ST_REL;
                    end
                end
                ST_REL: begin
                    // ak only falls once the resource has seen its request drop.
                    if (!res_ak_s) begin
                        ak_r    <= {N{1'b0}};
                        ptr_r   <= next_ptr_s;
                        busy_r  <= 1'b0;
                        wdog_r  <= {WD_W{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        wdog_r  <= wdog_inc_s;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ak_r     <= {N{1'b0}};
                    res_rq_r <= 1'b0;
                    busy_r   <= 1'b0;
                    wdog_r   <= {WD_W{1'b0}};
                end
            endcase
        end
    end

    // Sticky watchdog flag; the sequencer keeps waiting regardless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if ((TIMEOUT != 0) && (wdog_r == WD_MAX)) begin
            err_r <= 1'b1;
        end
    end

    assign ak      = ak_r;
    assign res_rq  = res_rq_r;
    assign res_sel = sel_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// Protocol checker for the arbiter's outputs: exclusion, owner stability, ordering.
module tkg_sync_arbiter_chk #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input logic             clk,
    input logic             reset_n,
    input logic [N-1:0]     ak,
    input logic             res_rq,
    input logic [IDX_W-1:0] res_sel,
    input logic             busy
);

    logic             prev_hold_r;
    logic             prev_rq_r;
    logic             prev_any_ak_r;
    logic [IDX_W-1:0] prev_sel_r;

    // History of the previous cycle's outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_hold_r   <= 1'b0;
            prev_rq_r     <= 1'b0;
            prev_any_ak_r <= 1'b0;
            prev_sel_r    <= {IDX_W{1'b0}};
        end else begin
            prev_hold_r   <= res_rq || (|ak);
            prev_rq_r     <= res_rq;
            prev_any_ak_r <= |ak;
            prev_sel_r    <= res_sel;
        end
    end

    // Immediate checks on every clock edge out of reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert ($onehot0(ak));
            if (|ak) begin
                assert (ak[res_sel] && busy);
            end
            if (prev_hold_r && (res_rq || (|ak))) begin
                assert (res_sel == prev_sel_r);
            end
            if (res_rq && !prev_rq_r) begin
                assert (ak == {N{1'b0}});
            end
            if ((|ak) && !prev_any_ak_r) begin
                assert (res_rq);
            end
        end
    end

endmodule

// File: tb/tb_tkg_sync_arbiter.sv
// Directed bench for tkg_sync_arbiter: N=4, two sync stages, watchdog of 8 cycles.
module tb_tkg_sync_arbiter;

    localparam int N       = 4;
    localparam int SYNC    = 2;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     rq;
    logic [N-1:0]     ak;
    logic             res_rq;
    logic [IDX_W-1:0] res_sel;
    logic             res_ak;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    int           res_dly   = 2;
    bit           res_stuck = 1'b0;
    int           res_cnt   = 0;
    logic [N-1:0] drop_en   = 4'b0000;
    logic [N-1:0] rearm_en  = 4'b0000;
    logic [N-1:0] ak_prev   = 4'b0000;
    logic [N-1:0] ak_old    = 4'b0000;
    logic [N-1:0] rq_smp    = 4'b0000;
    logic [IDX_W-1:0] glog[$];

    always #5 clk = ~clk;

    tkg_sync_arbiter #(.N(N), .SYNC_STAGES(SYNC), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .rq(rq), .ak(ak), .res_rq(res_rq),
        .res_sel(res_sel), .res_ak(res_ak), .busy(busy), .err(err)
    );

    tkg_sync_arbiter_chk #(.N(N), .IDX_W(IDX_W)) chk (
        .clk(clk), .reset_n(reset_n), .ak(ak), .res_rq(res_rq),
        .res_sel(res_sel), .busy(busy)
    );

    // One clock of the environment: resource follows res_rq after res_dly cycles,
    // requesters drop rq one cycle after their ak and optionally re-request.
    task automatic cycle();
        @(posedge clk);
        #1;
        rq_smp = rq;
        ak_old = ak_prev;
        if (!res_stuck && (res_rq !== res_ak)) begin
            res_cnt++;
            if (res_cnt > res_dly) begin
                res_ak  = res_rq;
                res_cnt = 0;
            end
        end else begin
            res_cnt = 0;
        end
        if ((ak != 4'b0000) && (ak_prev == 4'b0000)) glog.push_back(res_sel);
        for (int i = 0; i < N; i++) begin
            if (drop_en[i] && rq[i] && ak_prev[i] && ak[i]) rq[i] = 1'b0;
            else if (rearm_en[i] && !rq[i] && !ak[i]) rq[i] = 1'b1;
        end
        ak_prev = ak;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        rq = 4'b0000; res_ak = 1'b0; res_cnt = 0; res_dly = 2; res_stuck = 1'b0;
        drop_en = 4'b0000; rearm_en = 4'b0000; ak_prev = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        glog.delete();
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            cycle();
            if (!busy && rq == 4'b0000 && ak == 4'b0000 && !res_rq && !res_ak) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rq = 4'b0000; res_ak = 1'b0;
        #3;
        checks++;
        if ({ak, res_rq, res_sel, busy, err} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero", {ak, res_rq, res_sel, busy, err});
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) cycle();
        checks++;
        if ({ak, res_rq, res_sel, busy, err} !== 9'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b, want all zero", {ak, res_rq, res_sel, busy, err});
        end
    endtask

    task automatic test_single();
        bit ok;
        glog.delete();
        drop_en = 4'b0001;
        rq = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            cycle();
            checks++;
            if (res_rq !== (c == 3)) begin
                errors++;
                $display("FAIL single_latency c%0d: res_rq got %b, want %b", c, res_rq, (c == 3));
            end
        end
        checks++;
        if (res_sel !== 2'd0 || busy !== 1'b1 || ak !== 4'b0000) begin
            errors++;
            $display("FAIL single_req: sel/busy/ak got %0d/%b/%b, want 0/1/0000", res_sel, busy, ak);
        end
        repeat (4) cycle();
        checks++;
        if (ak !== 4'b0000) begin
            errors++;
            $display("FAIL single_ak_early: got %b, want 0000", ak);
        end
        cycle();
        checks++;
        if (ak !== 4'b0001 || res_rq !== 1'b1) begin
            errors++;
            $display("FAIL single_ak_rise: ak/res_rq got %b/%b, want 0001/1", ak, res_rq);
        end
        wait_quiet(60, ok);
        checks++;
        if (!ok || glog.size() != 1) begin
            errors++;
            $display("FAIL single_complete: quiet %b grants %0d, want 1 and 1", ok, glog.size());
        end
        // ptr is now 1: of requesters 0 and 2, requester 2 must win.
        drop_en = 4'b0101;
        rq = 4'b0101;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (res_rq) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || res_sel !== 2'd2) begin
            errors++;
            $display("FAIL single_ptr: res_rq %b sel %0d, want 1 and 2", ok, res_sel);
        end
        wait_quiet(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain: not quiet, busy %b rq %b", busy, rq);
        end
    endtask

    task automatic test_simultaneous();
        logic [IDX_W-1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bit ok;
        apply_reset();
        drop_en = 4'b1111;
        rearm_en = 4'b0001;
        rq = 4'b1111;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cycle();
            checks++;
            if (!$onehot0(ak)) begin
                errors++;
                $display("FAIL simul_onehot: ak got %b, want at most one bit", ak);
            end
            if (glog.size() >= 5) rearm_en = 4'b0000;
            if (glog.size() >= 5 && !busy && rq == 4'b0000 && !res_ak) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || glog.size() != 5) begin
            errors++;
            $display("FAIL simul_count: quiet %b grants %0d, want 1 and 5", ok, glog.size());
        end
        for (int k = 0; k < 5 && k < glog.size(); k++) begin
            checks++;
            if (glog[k] !== exp_order[k]) begin
                errors++;
                $display("FAIL simul_order[%0d]: got %0d, want %0d", k, glog[k], exp_order[k]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [IDX_W-1:0] exp_order [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        bit ok;
        apply_reset();
        drop_en = 4'b0101;
        rearm_en = 4'b0101;
        rq = 4'b0101;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cycle();
            if (glog.size() >= 4) rearm_en = 4'b0000;
            if (glog.size() >= 4 && !busy && rq == 4'b0000 && !res_ak) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || glog.size() < 4) begin
            errors++;
            $display("FAIL fair_count: quiet %b grants %0d, want 1 and >=4", ok, glog.size());
        end
        for (int k = 0; k < 4 && k < glog.size(); k++) begin
            checks++;
            if (glog[k] !== exp_order[k]) begin
                errors++;
                $display("FAIL fair_order[%0d]: got %0d, want %0d", k, glog[k], exp_order[k]);
            end
        end
    endtask

    task automatic test_stuck();
        bit ok;
        apply_reset();
        drop_en = 4'b0100;
        rq = 4'b0100;
        wait_quiet(100, ok);
        checks++;
        if (!ok || err !== 1'b0) begin
            errors++;
            $display("FAIL stuck_pre: quiet %b err %b, want 1 and 0", ok, err);
        end
        res_stuck = 1'b1;
        drop_en = 4'b0000;
        rq = 4'b0010;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stuck_enter: busy got %b, want 1", busy);
        end
        for (int c = 1; c <= 8; c++) begin
            cycle();
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL stuck_err_early c%0d: got %b, want 0", c, err);
            end
        end
        cycle();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL stuck_err_rise: got %b, want 1", err);
        end
        repeat (5) cycle();
        checks++;
        if ({busy, ak, res_rq, res_sel, err} !== {1'b1, 4'b0000, 1'b1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL stuck_hold: busy/ak/res_rq/sel/err got %b/%b/%b/%0d/%b, want 1/0000/1/1/1",
                     busy, ak, res_rq, res_sel, err);
        end
    endtask

    task automatic test_reset_hold();
        bit ok;
        res_stuck = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (ak == 4'b0010) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || res_rq !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL hold_enter: ak %b res_rq %b err %b, want 0010/1/1", ak, res_rq, err);
        end
        rq = 4'b1010;
        repeat (4) cycle();
        checks++;
        if (ak !== 4'b0010) begin
            errors++;
            $display("FAIL hold_pending: ak got %b, want 0010", ak);
        end
        reset_n = 1'b0;
        res_ak = 1'b0;
        res_cnt = 0;
        #2;
        checks++;
        if ({ak, res_rq, err, busy} !== 7'd0) begin
            errors++;
            $display("FAIL hold_async_reset: ak/res_rq/err/busy got %b/%b/%b/%b, want zero",
                     ak, res_rq, err, busy);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ak_prev = 4'b0000;
        glog.delete();
        drop_en = 4'b1010;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (res_rq) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || res_sel !== 2'd1) begin
            errors++;
            $display("FAIL hold_regrant: res_rq %b sel %0d, want 1 and 1", ok, res_sel);
        end
        wait_quiet(200, ok);
        checks++;
        if (!ok || glog.size() != 2 || glog[0] !== 2'd1 || glog[1] !== 2'd3) begin
            errors++;
            $display("FAIL hold_order: quiet %b grants %0d, want 1 and order 1,3", ok, glog.size());
        end
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1;
        rq[2] = 1'b1;
        #3;
        rq[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            checks++;
            if (res_rq !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL glitch c%0d: res_rq/busy got %b/%b, want 0/0", c, res_rq, busy);
            end
        end
    endtask

    task automatic test_stall_sweep();
        bit ok;
        glog.delete();
        drop_en = 4'b1111;
        for (int c = 0; c < 600; c++) begin
            if (res_rq === res_ak) res_dly = $urandom_range(0, 3);
            rearm_en = 4'($urandom_range(0, 15));
            cycle();
            checks++;
            if (!$onehot0(ak) || (ak != 4'b0000 && !ak[res_sel])) begin
                errors++;
                $display("FAIL sweep_excl: ak %b sel %0d, want one-hot owned by sel", ak, res_sel);
            end
            for (int i = 0; i < N; i++) begin
                if (ak_old[i] && !ak[i]) begin
                    checks++;
                    if (rq_smp[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL sweep_order[%0d]: ak fell with rq %b, want rq 0", i, rq_smp[i]);
                    end
                end
            end
        end
        rearm_en = 4'b0000;
        wait_quiet(300, ok);
        checks++;
        if (!ok || err !== 1'b0 || glog.size() < 10) begin
            errors++;
            $display("FAIL sweep_end: quiet %b err %b grants %0d, want 1/0/>=10", ok, err, glog.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_stuck();
        test_reset_hold();
        test_glitch();
        test_stall_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
